// File: rtl/iter_shift_ctrl_pkg.sv
// iter_shift_ctrl_pkg: op and FSM state encodings shared by the controller and the shift datapath
package iter_shift_ctrl_pkg;
    typedef enum logic [1:0] {ROL = 2'b00, SLL = 2'b01, ROR = 2'b10, SRL = 2'b11} op_e;
    typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_e;
    function automatic logic is_right(op_e op);
        return op[1];
    endfunction
    function automatic logic is_logical(op_e op);
        return op[0];
    endfunction
endpackage

// File: rtl/iter_shift_ctrl_if.sv
// iter_shift_ctrl_if: request/result signals between a requester and the iterative shifter
interface iter_shift_ctrl_if #(parameter int WIDTH = 16, parameter int CNT_W = 4);
    import iter_shift_ctrl_pkg::*;
    logic start;
    logic [WIDTH-1:0] In;
    logic [CNT_W-1:0] Cnt;
    op_e Op;
    logic ready;
    logic busy;
    logic done;
    logic [WIDTH-1:0] Out;
    modport master(output start, In, Cnt, Op, input ready, busy, done, Out);
    modport slave(input start, In, Cnt, Op, output ready, busy, done, Out);
endinterface

// File: rtl/mux2_1.sv
// mux2_1: two-input multiplexer cell, selects b when s is high
module mux2_1 #(parameter int W = 1) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output logic [W-1:0] y
);
    assign y = s ? b : a;
endmodule

// File: rtl/shift1_stage.sv
// shift1_stage: combinational one-bit shift/rotate of data under the given op
module shift1_stage import iter_shift_ctrl_pkg::*; #(parameter int WIDTH = 16) (
    input  logic [WIDTH-1:0] data,
    input  op_e              op,
    output logic [WIDTH-1:0] y
);
    logic fill_l, fill_r, logical, right;
    assign logical = is_logical(op);
    assign right = is_right(op);
    // the vacated end takes the wrapped-out bit for rotates, zero for logical shifts
    mux2_1 u_fill_l (.a(data[WIDTH-1]), .b(1'b0), .s(logical), .y(fill_l));
    mux2_1 u_fill_r (.a(data[0]), .b(1'b0), .s(logical), .y(fill_r));
    mux2_1 #(.W(WIDTH)) u_dir (
        .a({data[WIDTH-2:0], fill_l}),
        .b({fill_r, data[WIDTH-1:1]}),
        .s(right),
        .y(y)
    );
endmodule

// File: rtl/iter_shift_ctrl.sv
// iter_shift_ctrl: multi-cycle shifter/rotator applying one bit position per clock
module iter_shift_ctrl import iter_shift_ctrl_pkg::*; #(parameter int WIDTH = 16, parameter int CNT_W = 4) (
    input logic clk,
    input logic rst_n,
    iter_shift_ctrl_if.slave bus
);
    state_e state, state_n;
    logic [WIDTH-1:0] data, data_n, step, out_q, out_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    op_e op, op_n;
    shift1_stage #(.WIDTH(WIDTH)) u_step (.data(data), .op(op), .y(step));
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            data <= '0;
            cnt <= '0;
            op <= ROL;
            out_q <= '0;
        end else begin
            state <= state_n;
            data <= data_n;
            cnt <= cnt_n;
            op <= op_n;
            out_q <= out_n;
        end
    end
    always_comb begin
        state_n = state;
        data_n = data;
        cnt_n = cnt;
        op_n = op;
        case (state)
            IDLE: if (bus.start) begin
                data_n = bus.In;
                cnt_n = bus.Cnt;
                op_n = bus.Op;
                state_n = (bus.Cnt != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                data_n = step;
                cnt_n = cnt - CNT_W'(1);
                state_n = (cnt == CNT_W'(1)) ? DONE : SHIFT;
            end
            default: state_n = IDLE;
        endcase
        // result register only updates on entry to DONE so partial shifts stay hidden
        out_n = (state_n == DONE) ? data_n : out_q;
    end
    assign bus.ready = state == IDLE;
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
    assign bus.Out = out_q;
endmodule

// File: tb/tb_iter_shift_ctrl.sv
// tb_iter_shift_ctrl: scoreboard bench for iter_shift_ctrl against an arithmetic shift/rotate model
module tb_iter_shift_ctrl;
    import iter_shift_ctrl_pkg::*;
    typedef struct {logic [15:0] res; int edge_n;} exp_t;
    logic clk = 0;
    logic rst_n = 0;
    iter_shift_ctrl_if #(.WIDTH(16), .CNT_W(4)) bus();
    iter_shift_ctrl #(.WIDTH(16), .CNT_W(4)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    exp_t q[$];
    int cyc = 0, free_edge = 1, errors = 0, checks = 0;
    logic [15:0] last_out = '0;
    logic dval = 0;
    logic [15:0] dexp = '0;
    logic s_rst = 0, s_start = 0, s_dval = 0;
    logic [15:0] s_in = '0, s_dexp = '0;
    logic [3:0] s_cnt = '0;
    logic [1:0] s_op = '0;

    function automatic logic [15:0] model(logic [15:0] x, int n, logic [1:0] op);
        logic [31:0] dbl = {x, x};
        logic [31:0] z = {16'h0, x};
        case (op)
            2'b00: return 16'((dbl << n) >> 16);
            2'b01: return 16'(z << n);
            2'b10: return 16'(dbl >> n);
            default: return 16'(z >> n);
        endcase
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        s_rst <= rst_n;
        s_start <= bus.start;
        s_in <= bus.In;
        s_cnt <= bus.Cnt;
        s_op <= bus.Op;
        s_dval <= dval;
        s_dexp <= dexp;
    end

    // model: an accepted request finishes Cnt edges later and frees the block one edge after that
    initial forever begin
        logic rdy_exp, done_exp;
        @(negedge clk);
        if (!s_rst) begin
            q.delete();
            last_out = '0;
            free_edge = cyc + 1;
        end else if (s_start && cyc >= free_edge) begin
            q.push_back('{s_dval ? s_dexp : model(s_in, int'(s_cnt), s_op), cyc + int'(s_cnt)});
            free_edge = cyc + int'(s_cnt) + 2;
        end
        rdy_exp = cyc >= free_edge - 1;
        done_exp = q.size() > 0 && q[0].edge_n == cyc;
        chk("ready", 16'(bus.ready), 16'(rdy_exp));
        chk("busy", 16'(bus.busy), 16'(!rdy_exp));
        chk("done", 16'(bus.done), 16'(done_exp));
        if (done_exp) last_out = q.pop_front().res;
        chk("out", bus.Out, last_out);
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (cyc < free_edge - 1 && n < 60);
        if (cyc < free_edge - 1) chk("idle_timeout", 16'(cyc), 16'(free_edge - 1));
    endtask

    task automatic issue(logic [15:0] in, logic [3:0] cnt, logic [1:0] op, logic dv, logic [15:0] de);
        wait_idle();
        bus.start = 1;
        bus.In = in;
        bus.Cnt = cnt;
        bus.Op = op_e'(op);
        dval = dv;
        dexp = de;
        @(negedge clk);
        #1;
        bus.start = 0;
        dval = 0;
        bus.In = 16'($urandom);
        bus.Cnt = 4'($urandom);
        bus.Op = op_e'($urandom_range(0, 3));
    endtask

    initial begin
        bus.start = 0;
        bus.In = '0;
        bus.Cnt = '0;
        bus.Op = ROL;
        repeat (3) @(negedge clk);
        #1 rst_n = 1;
        issue(16'h0001, 4, 2'b01, 1, 16'h0010);
        issue(16'h8000, 15, 2'b11, 1, 16'h0001);
        issue(16'hFFFF, 8, 2'b11, 1, 16'h00FF);
        issue(16'h8001, 1, 2'b00, 1, 16'h0003);
        issue(16'h8001, 1, 2'b10, 1, 16'hC000);
        issue(16'hA5A5, 0, 2'b11, 1, 16'hA5A5);
        issue(16'h8001, 15, 2'b00, 1, 16'hC000);
        issue(16'h8001, 15, 2'b10, 1, 16'h0003);
        // a start pulse mid-shift with a different operand must be ignored
        issue(16'h1234, 10, 2'b00, 0, '0);
        repeat (3) @(negedge clk);
        #1 bus.start = 1;
        bus.In = 16'hFFFF;
        @(negedge clk);
        #1 bus.start = 0;
        wait_idle();
        bus.start = 1;
        bus.In = 16'h00F1;
        bus.Cnt = 3;
        bus.Op = ROR;
        repeat (20) @(negedge clk);
        #1 bus.start = 0;
        issue(16'hBEEF, 10, 2'b01, 0, '0);
        repeat (4) @(negedge clk);
        #1 rst_n = 0;
        @(negedge clk);
        #1 rst_n = 1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            issue(16'($urandom), 4'($urandom), 2'($urandom), 0, '0);
            for (int j = 0; j < int'($urandom_range(0, 5)); j++) begin
                bus.start = 1'($urandom);
                bus.In = 16'($urandom);
                @(negedge clk);
                #1;
            end
            bus.start = 0;
        end
        wait_idle();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
